key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Input conditioning stage for the push-button keys. It sits between the raw active-low KEY pins and the clock/stopwatch/timer/alarm control logic. Per key, it synchronises, debounces and edge-detects the input. It emits single-cycle press/release pulses and an auto-repeat pulse train, so that set-mode increment inputs advance once per press, or at a steady rate while held.

Parameters:
NUM_KEYS, 3, number of independent key channels.
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz); minimum 2.
REPEAT_DELAY, 25000000, held cycles after the accepted press before the first auto-repeat pulse (0.5 s).
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses (0.1 s).

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high reset.
key_n  input  NUM_KEYS  raw key pins, active-low (0 = pressed), asynchronous to CLOCK_50.
repeat_en  input  NUM_KEYS  per-key auto-repeat enable, synchronous.
key_level  output  NUM_KEYS  debounced level, active-high (1 = held).
key_press  output  NUM_KEYS  1-cycle pulse on accepted press.
key_release  output  NUM_KEYS  1-cycle pulse on accepted release.
key_repeat  output  NUM_KEYS  1-cycle pulse on press plus auto-repeat ticks.

Behaviour:
- Reset state: all outputs 0; synchroniser flops = 1 (released); debounce counters = 0; repeat FSMs = IDLE; repeat timers = 0.
- Synchroniser: 2-flop chain per key on key_n. sync = second flop, inverted, so 1 = pressed.
- Debounce, per key: stable register drives key_level.
  - While sync != stable, the counter increments each cycle.
  - If sync == stable, the counter clears to 0.
  - When sync != stable and counter == DEBOUNCE_CYCLES-1, then on that edge: stable <= sync and counter <= 0.
- Latency: if edge k is the first edge to sample key_n low, key_level rises after edge k+DEBOUNCE_CYCLES+1. Release has the same latency.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES samples never changes key_level. Any bounce restarts the count.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter never wraps.
- key_press: asserted for exactly the cycle after the edge where stable goes 0->1, i.e. coincident with key_level first reading 1.
- key_release: the same, for stable going 1->0.
- Repeat FSM, per key, states IDLE / DELAY / REPEAT:
  - IDLE: on the accepted press (same edge stable goes 0->1), key_repeat pulses with key_press, timer <= 0, go to DELAY.
  - DELAY: timer increments each cycle while held and repeat_en=1. If repeat_en=0, timer holds and no pulses are generated. When timer == REPEAT_DELAY-1: pulse key_repeat, timer <= 0, go to REPEAT.
  - REPEAT: timer increments; when timer == REPEAT_RATE-1: pulse key_repeat, timer <= 0. If repeat_en drops, timer holds and no pulses.
  - Any state: an accepted release (stable 1->0) goes to IDLE and clears the timer. No repeat pulse is issued on the release edge, even if the timer matches on that edge; release wins.
- Repeat timer width: clog2(max(REPEAT_DELAY, REPEAT_RATE)).
- Channels are fully independent. Simultaneous presses on several keys produce pulses on the same cycle with no arbitration.
- Reset mid-operation: asynchronous return to the reset state. No key_press, key_release or key_repeat pulse is generated by the reset itself, nor by its release while a key is held. A key held through reset deassertion is accepted as a fresh press after the full debounce latency.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, NUM_KEYS=3.)
1. Clean press: key_n[0] driven 1->0 before edge 0 and held -> key_level[0] rises after edge 5. key_press[0] and key_repeat[0] are high for exactly that one cycle; the other channels stay 0.
2. Bounce: key_n[1] low 3 cycles, high 1, low 3, high 1, then low steady -> no output activity until 4 consecutive low samples; then exactly one key_press[1].
3. Auto-repeat, key_n[2] held 40 cycles with repeat_en[2]=1 -> key_repeat pulses at press cycle P, then P+10, P+13, P+16... On release, key_release[2] pulses once and key_repeat stops.
4. repeat_en=0 while holding 30 cycles -> only the initial key_repeat pulse. Raising repeat_en resumes counting from the held timer value.
5. Simultaneous: all three keys pressed on the same edge -> key_press = 3'b111 on a single cycle. A release during the REPEAT timer match cycle gives no extra key_repeat pulse.
6. Reset: assert reset mid-hold in the REPEAT state -> outputs are 0 immediately (asynchronous). After deassertion with the key still held, key_press fires after the full debounce latency (deassert edge +5), with no pulse on deassertion.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button conditioning: per key, a 2-flop synchroniser, a debouncer, press/release
// edge pulses and an auto-repeat pulse train for held keys.
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic             sync_meta;
    logic             sync_q;
    logic             sync;
    logic             stable;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    rep_state_t       state;
    logic [TMR_W-1:0] timer;

    assign sync   = ~sync_q;
    assign accept = (sync != stable) && (count == CNT_LAST);

    // Synchroniser resets to the released level so reset itself never looks like a press.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        sync_meta <= 1'b1;
        sync_q    <= 1'b1;
      end else begin
        sync_meta <= key_n[i];
        sync_q    <= sync_meta;
      end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        stable    <= 1'b0;
        count     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= accept & sync;
        release_q <= accept & ~sync;
        if (sync == stable) begin
          count <= '0;
        end else if (count == CNT_LAST) begin
          stable <= sync;
          count  <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end

    // An accepted release always wins, even on the edge where the timer would match.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        timer    <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (accept && !sync) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (accept && sync) begin
                repeat_q <= 1'b1;
                timer    <= '0;
                state    <= DELAY;
              end
            end
            DELAY: begin
              if (repeat_en[i]) begin
                if (timer == DELAY_LAST) begin
                  repeat_q <= 1'b1;
                  timer    <= '0;
                  state    <= REPEAT;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
            end
            REPEAT: begin
              if (repeat_en[i]) begin
                if (timer == RATE_LAST) begin
                  repeat_q <= 1'b1;
                  timer    <= '0;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
            end
            default: begin
              state <= IDLE;
              timer <= '0;
            end
          endcase
        end
      end
    end

    assign key_level[i]   = stable;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/repeat parameters: phase table with a
// queued scoreboard plus cycle-exact sequences for repeat timing, simultaneity and reset.
module tb_key_conditioner;

  localparam int NK  = 3;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = DEB + 1;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [NK-1:0] key_n     = '1;
  logic [NK-1:0] repeat_en = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;

  int total = 0;
  int bad   = 0;
  int press_cnt   [NK];
  int release_cnt [NK];
  int repeat_cnt  [NK];

  typedef struct {
    logic [NK-1:0] key_n;
    logic [NK-1:0] rep_en;
    int            cycles;
    logic [NK-1:0] exp_level;
    logic [NK-1:0] exp_press;
    logic [NK-1:0] exp_release;
    logic [NK-1:0] exp_repeat;
  } vec_t;

  vec_t vecs [10];
  vec_t exp_q [$];
  int   rep_q [$];

  key_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .key_n(key_n),
    .repeat_en(repeat_en),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_repeat(key_repeat)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drives one phase of the table and tallies pulses per channel.
  task automatic applyStimulus(input vec_t v);
    exp_q.push_back(v);
    key_n     = v.key_n;
    repeat_en = v.rep_en;
    for (int k = 0; k < NK; k++) begin
      press_cnt[k]   = 0;
      release_cnt[k] = 0;
      repeat_cnt[k]  = 0;
    end
    for (int c = 0; c < v.cycles; c++) begin
      tick();
      for (int k = 0; k < NK; k++) begin
        press_cnt[k]   += int'(key_press[k]);
        release_cnt[k] += int'(key_release[k]);
        repeat_cnt[k]  += int'(key_repeat[k]);
      end
    end
  endtask

  task automatic checkPhase(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    checkOutput($sformatf("v%0d level", idx), 32'(key_level), 32'(e.exp_level));
    for (int k = 0; k < NK; k++) begin
      checkOutput($sformatf("v%0d press%0d", idx, k), press_cnt[k], 32'(e.exp_press[k]));
      checkOutput($sformatf("v%0d release%0d", idx, k), release_cnt[k], 32'(e.exp_release[k]));
      checkOutput($sformatf("v%0d repeat%0d", idx, k), repeat_cnt[k], 32'(e.exp_repeat[k]));
    end
  endtask

  // Holds key k from tick 0 to rel_at; repeat_en[k] low for ticks [en_lo_from, en_lo_to).
  task automatic runSeq(input string tag, input int k, input int cycles, input int rel_at,
                        input int en_lo_from, input int en_lo_to);
    logic          exp_rep;
    logic [NK-1:0] others;
    others    = '1;
    others[k] = 1'b0;
    for (int t = 0; t < cycles; t++) begin
      key_n[k]     = (t < rel_at) ? 1'b0 : 1'b1;
      repeat_en[k] = (t >= en_lo_from && t < en_lo_to) ? 1'b0 : 1'b1;
      tick();
      exp_rep = (rep_q.size() > 0) && (rep_q[0] == t);
      if (exp_rep) void'(rep_q.pop_front());
      checkOutput($sformatf("%s repeat t=%0d", tag, t), 32'(key_repeat[k]), 32'(exp_rep));
      checkOutput($sformatf("%s press t=%0d", tag, t), 32'(key_press[k]), 32'(t == LAT));
      checkOutput($sformatf("%s release t=%0d", tag, t), 32'(key_release[k]), 32'(t == rel_at + LAT));
      checkOutput($sformatf("%s level t=%0d", tag, t), 32'(key_level[k]),
                  32'(t >= LAT && t < rel_at + LAT));
      checkOutput($sformatf("%s others t=%0d", tag, t),
                  32'((key_press | key_repeat | key_level) & others), 32'd0);
    end
    checkOutput($sformatf("%s missing repeats", tag), rep_q.size(), 0);
    rep_q.delete();
  endtask

  initial begin
    vecs[0] = '{3'b111, 3'b111,  8, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1] = '{3'b110, 3'b111,  8, 3'b001, 3'b001, 3'b000, 3'b001};
    vecs[2] = '{3'b111, 3'b111,  8, 3'b000, 3'b000, 3'b001, 3'b000};
    vecs[3] = '{3'b101, 3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[4] = '{3'b111, 3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[5] = '{3'b101, 3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[6] = '{3'b111, 3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[7] = '{3'b101, 3'b111, 10, 3'b010, 3'b010, 3'b000, 3'b010};
    vecs[8] = '{3'b111, 3'b111, 10, 3'b000, 3'b000, 3'b010, 3'b000};
    vecs[9] = '{3'b111, 3'b111,  4, 3'b000, 3'b000, 3'b000, 3'b000};

    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset level", 32'(key_level), 32'd0);
    checkOutput("reset press", 32'(key_press), 32'd0);
    checkOutput("reset release", 32'(key_release), 32'd0);
    checkOutput("reset repeat", 32'(key_repeat), 32'd0);
    reset = 1'b0;

    rep_q.push_back(LAT);
    runSeq("clean", 0, 16, 8, -1, -1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkPhase(i);
    end

    // Held 40 cycles, release lands on a REPEAT timer match and must not pulse.
    rep_q.push_back(LAT);
    for (int r = LAT + RD; r <= 42; r += RR) rep_q.push_back(r);
    runSeq("autorep", 2, 50, 40, -1, -1);

    // Timer frozen at 4 while disabled; resumes and matches 5 cycles after re-enable.
    rep_q.push_back(LAT);
    rep_q.push_back(45);
    rep_q.push_back(48);
    rep_q.push_back(51);
    rep_q.push_back(54);
    runSeq("en_hold", 0, 60, 50, 10, 40);

    key_n = 3'b000;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (t == LAT - 1) checkOutput("simul press early", 32'(key_press), 32'd0);
      if (t == LAT) begin
        checkOutput("simul press", 32'(key_press), 32'b111);
        checkOutput("simul repeat", 32'(key_repeat), 32'b111);
        checkOutput("simul level", 32'(key_level), 32'b111);
      end
      if (t == LAT + 1) checkOutput("simul press late", 32'(key_press), 32'd0);
    end
    key_n = 3'b111;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (t == LAT) checkOutput("simul release", 32'(key_release), 32'b111);
    end
    checkOutput("simul level off", 32'(key_level), 32'd0);

    key_n[2] = 1'b0;
    for (int t = 0; t < 20; t++) tick();
    checkOutput("prereset level", 32'(key_level[2]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async level", 32'(key_level), 32'd0);
    checkOutput("async press", 32'(key_press), 32'd0);
    checkOutput("async release", 32'(key_release), 32'd0);
    checkOutput("async repeat", 32'(key_repeat), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      checkOutput($sformatf("post press t=%0d", t), 32'(key_press[2]), 32'(t == LAT));
      checkOutput($sformatf("post repeat t=%0d", t), 32'(key_repeat[2]), 32'(t == LAT));
      checkOutput($sformatf("post level t=%0d", t), 32'(key_level[2]), 32'(t >= LAT));
      checkOutput($sformatf("post release t=%0d", t), 32'(key_release), 32'd0);
    end
    key_n = 3'b111;
    for (int t = 0; t < 12; t++) tick();
    checkOutput("final level", 32'(key_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
